hazard_scoreboard_ctrl: RTL and testbench
=========================================

// Module: hazard_scoreboard_ctrl
// PURPOSE
//  Issue/stall controller sitting beside the ID stage and the operand-forwarding logic.
//  Forwarding cannot resolve two cases: load-use hazards, and operands still pending from
//  the multi-cycle MUL/DIV unit (MDU). This block tracks MDU destinations in a register
//  scoreboard and generates the stall and bubble controls for those cases. It also
//  arbitrates the single register-file write port between pipeline writeback and MDU results.
// PARAMETERS
//  MDU_DEPTH   2   max MDU ops in flight (1..4); structural stall when reached
//  CNT_W       32  width of the stall-cycle performance counter
// PORTS
//  clk_i             in   1      clock
//  rst_ni            in   1      async active-low reset
//  ID_valid_i        in   1      valid instruction in ID
//  ID_rs1_addr_i     in   5      ID source 1
//  ID_rs2_addr_i     in   5      ID source 2
//  ID_rs1_used_i     in   1      instruction reads rs1
//  ID_rs2_used_i     in   1      instruction reads rs2
//  ID_rd_addr_i      in   5      ID destination
//  ID_RegWrite_i     in   1      instruction writes rd
//  ID_is_mdu_i       in   1      instruction is an MDU op
//  EX_MemRead_i      in   1      EX holds a load
//  EX_rd_addr_i      in   5      EX destination
//  flush_i           in   1      branch/jump flush of IF/ID
//  WB_RegWrite_i     in   1      pipeline writeback wants the RF port this cycle
//  mdu_done_i        in   1      MDU result valid (held until accepted)
//  mdu_rd_addr_i     in   5      MDU result destination
//  stall_o           out  1      hold PC and IF/ID
//  bubble_o          out  1      load NOP into ID/EX
//  mdu_issue_o       out  1      MDU op leaves ID this cycle
//  mdu_ack_o         out  1      MDU result accepted this cycle
//  wb_sel_mdu_o      out  1      RF write port source: 0 pipeline, 1 MDU
//  busy_o            out  32     scoreboard; bit0 always 0
//  stall_cnt_o       out  CNT_W  cycles with stall_o=1, saturating
// BEHAVIOUR
//  Reset (async, rst_ni=0): busy_o=0, outstanding count=0, stall_cnt_o=0.
//   All combinational outputs then follow their input equations.
//  Hazard terms (each requires ID_valid_i=1; register x0 never matches):
//   lu  : EX_MemRead_i & EX_rd!=0 & (rs1_used & rs1==EX_rd | rs2_used & rs2==EX_rd)
//   raw : (rs1_used & busy[rs1]) | (rs2_used & busy[rs2])
//   waw : ID_RegWrite_i & busy[ID_rd]
//   st  : ID_is_mdu_i & (count==MDU_DEPTH)
//  stall_o = (lu|raw|waw|st) & ~flush_i
//  bubble_o = stall_o | flush_i
//  mdu_issue_o = ID_valid_i & ID_is_mdu_i & ~stall_o & ~flush_i
//  WB arbitration, same cycle, pipeline has fixed priority:
//   mdu_ack_o = mdu_done_i & ~WB_RegWrite_i
//   wb_sel_mdu_o = mdu_ack_o
//   The MDU holds its result until acked; a starved MDU result keeps its rd busy.
//  Scoreboard update on posedge:
//   mdu_issue_o & ID_rd!=0 sets busy[ID_rd].
//   mdu_ack_o clears busy[mdu_rd_addr_i].
//   Set and clear of the same index cannot coincide, because waw stalls the issue.
//   Any index 0 update is ignored.
//  Outstanding count: +1 on mdu_issue_o, -1 on mdu_ack_o, unchanged when both occur.
//   It never exceeds MDU_DEPTH or drops below 0; an ack with count==0 is ignored.
//  stall_cnt_o increments each cycle stall_o=1 and saturates at all-ones.
//  Latency: all control outputs are combinational from the inputs.
//   busy_o and the count take effect from the cycle after the update.
//  Reset mid-operation clears the scoreboard immediately.
//   The MDU must be reset by the same rst_ni.
// TESTING
//  Load-use: EX_MemRead=1 EX_rd=5, ID rs1=5 used -> stall_o=1, bubble_o=1 for 1 cycle;
//   next cycle (EX_MemRead=0) stall_o=0.
//  MDU RAW: issue MUL rd=7; next ID reads rs2=7 -> stall_o=1 until mdu_done_i rd=7 is acked;
//   busy_o[7] clears in the following cycle.
//  Arbitration: mdu_done_i=1 with WB_RegWrite_i=1 for 3 cycles -> mdu_ack_o=0 for those cycles;
//   on cycle 4 (WB_RegWrite_i=0) mdu_ack_o=1, wb_sel_mdu_o=1.
//  Structural: MDU_DEPTH=2, issue rd=3 and rd=4 with no acks; a third MDU op -> stall_o=1.
//   One ack -> it issues the next cycle.
//  Flush precedence: flush_i=1 with a raw hazard and an MDU op in ID -> stall_o=0, bubble_o=1,
//   mdu_issue_o=0, busy_o unchanged.
//  x0 / reset: MDU op rd=0 -> busy_o stays 0; assert rst_ni=0 with busy_o[9]=1 and stall_cnt_o=12
//   -> busy_o=0 and stall_cnt_o=0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl.sv
// Issue/stall controller for load-use and MDU operand hazards, with an MDU destination
// scoreboard and register-file write-port arbitration between pipeline WB and the MDU.
module hazard_scoreboard_ctrl #(
  parameter int MDU_DEPTH = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ID_valid_i,
  input  logic [4:0]       ID_rs1_addr_i,
  input  logic [4:0]       ID_rs2_addr_i,
  input  logic             ID_rs1_used_i,
  input  logic             ID_rs2_used_i,
  input  logic [4:0]       ID_rd_addr_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_is_mdu_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rd_addr_i,
  input  logic             flush_i,
  input  logic             WB_RegWrite_i,
  input  logic             mdu_done_i,
  input  logic [4:0]       mdu_rd_addr_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             mdu_issue_o,
  output logic             mdu_ack_o,
  output logic             wb_sel_mdu_o,
  output logic [31:0]      busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [2:0] DEPTH_C = 3'(MDU_DEPTH);

  logic [31:0]      busy_r;
  logic [2:0]       count_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic        lu_s;
  logic        raw_s;
  logic        waw_s;
  logic        st_s;
  logic        stall_s;
  logic        issue_s;
  logic        ack_s;
  logic [31:0] set_s;
  logic [31:0] clr_s;
  logic [31:0] busy_nxt_s;
  logic [2:0]  count_nxt_s;

  // Hazard detection; busy_r[0] is held at 0, so x0 sources never see a scoreboard hit.
  always_comb begin
    lu_s    = ID_valid_i & EX_MemRead_i & (EX_rd_addr_i != 5'd0) &
              ((ID_rs1_used_i & (ID_rs1_addr_i == EX_rd_addr_i)) |
               (ID_rs2_used_i & (ID_rs2_addr_i == EX_rd_addr_i)));
    raw_s   = ID_valid_i & ((ID_rs1_used_i & busy_r[ID_rs1_addr_i]) |
                            (ID_rs2_used_i & busy_r[ID_rs2_addr_i]));
    waw_s   = ID_valid_i & ID_RegWrite_i & busy_r[ID_rd_addr_i];
    st_s    = ID_valid_i & ID_is_mdu_i & (count_r == DEPTH_C);
    stall_s = (lu_s | raw_s | waw_s | st_s) & ~flush_i;
    issue_s = ID_valid_i & ID_is_mdu_i & ~stall_s & ~flush_i;
    ack_s   = mdu_done_i & ~WB_RegWrite_i;
  end

  // Scoreboard and in-flight count next state.
  always_comb begin
    set_s      = (issue_s && (ID_rd_addr_i != 5'd0)) ? (32'd1 << ID_rd_addr_i) : 32'd0;
    clr_s      = ack_s ? (32'd1 << mdu_rd_addr_i) : 32'd0;
    busy_nxt_s = (busy_r | set_s) & ~clr_s & ~32'd1;
    count_nxt_s = count_r;
    case ({issue_s, ack_s})
      2'b10: begin
        if (count_r < DEPTH_C) begin
          count_nxt_s = count_r + 3'd1;
        end else begin
          count_nxt_s = count_r;
        end
      end
      2'b01: begin
        if (count_r != 3'd0) begin
          count_nxt_s = count_r - 3'd1;
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // State registers; the stall counter saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r      <= 32'd0;
      count_r     <= 3'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      count_r <= count_nxt_s;
      if (stall_s && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_o      = stall_s;
  assign bubble_o     = stall_s | flush_i;
  assign mdu_issue_o  = issue_s;
  assign mdu_ack_o    = ack_s;
  assign wb_sel_mdu_o = ack_s;
  assign busy_o       = busy_r;
  assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: combinational vector table plus
// multi-cycle sequences for MDU RAW, arbitration, structural, flush, x0 and reset.
module tb_hazard_scoreboard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_u1;
  logic             id_u2;
  logic [4:0]       id_rd;
  logic             id_rw;
  logic             id_mdu;
  logic             ex_mr;
  logic [4:0]       ex_rd;
  logic             flush;
  logic             wb_rw;
  logic             mdu_done;
  logic [4:0]       mdu_rd;
  logic             stall;
  logic             bubble;
  logic             mdu_issue;
  logic             mdu_ack;
  logic             wb_sel_mdu;
  logic [31:0]      busy;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mdu;
    logic       exmr;
    logic [4:0] exrd;
    logic       flush;
    logic       wbrw;
    logic       done;
    logic [4:0] mdurd;
    logic       e_stall;
    logic       e_bubble;
    logic       e_issue;
    logic       e_ack;
  } vec_t;

  vec_t vecs [11];

  hazard_scoreboard_ctrl #(.MDU_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ID_valid_i(id_valid), .ID_rs1_addr_i(id_rs1), .ID_rs2_addr_i(id_rs2),
    .ID_rs1_used_i(id_u1), .ID_rs2_used_i(id_u2), .ID_rd_addr_i(id_rd),
    .ID_RegWrite_i(id_rw), .ID_is_mdu_i(id_mdu),
    .EX_MemRead_i(ex_mr), .EX_rd_addr_i(ex_rd), .flush_i(flush),
    .WB_RegWrite_i(wb_rw), .mdu_done_i(mdu_done), .mdu_rd_addr_i(mdu_rd),
    .stall_o(stall), .bubble_o(bubble), .mdu_issue_o(mdu_issue), .mdu_ack_o(mdu_ack),
    .wb_sel_mdu_o(wb_sel_mdu), .busy_o(busy), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_u1 = 1'b0; id_u2 = 1'b0;
    id_rd = 5'd0; id_rw = 1'b0; id_mdu = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;
    flush = 1'b0; wb_rw = 1'b0; mdu_done = 1'b0; mdu_rd = 5'd0;
  endtask

  // Advance one clock; the expected stall decides whether the counter model steps.
  task automatic tick(input logic exp_stall);
    if (exp_stall && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mdu(input logic [4:0] rd);
    idle();
    id_valid = 1'b1; id_mdu = 1'b1; id_rw = 1'b1; id_rd = rd;
  endtask

  task automatic drive_lu();
    idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_u1 = 1'b1; ex_mr = 1'b1; ex_rd = 5'd5;
  endtask

  initial begin
    vecs[0]  = '{1'b1,5'd5,5'd0,1'b1,1'b0,5'd6,1'b1,1'b0,1'b1,5'd5,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b1,5'd1,5'd5,1'b1,1'b0,5'd6,1'b1,1'b0,1'b1,5'd5,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,5'd1,5'd5,1'b1,1'b1,5'd6,1'b1,1'b0,1'b1,5'd5,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b1,5'd0,5'd0,1'b1,1'b1,5'd6,1'b1,1'b0,1'b1,5'd0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,5'd5,5'd0,1'b1,1'b0,5'd6,1'b1,1'b0,1'b1,5'd5,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b1,5'd5,5'd0,1'b1,1'b0,5'd6,1'b1,1'b0,1'b1,5'd5,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b1,5'd2,5'd3,1'b1,1'b1,5'd6,1'b1,1'b0,1'b0,5'd0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b1,5'd5,5'd0,1'b1,1'b0,5'd6,1'b1,1'b0,1'b0,5'd5,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b1,5'd7, 1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,5'd7, 1'b0,1'b0,1'b0,1'b1};
    vecs[10] = '{1'b1,5'd4,5'd12,1'b1,1'b1,5'd6,1'b1,1'b0,1'b1,5'd12,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0,1'b0};

    rst_n = 1'b0;
    idle();
    #12;
    chk("reset_busy", busy, 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_bubble", 32'(bubble), 32'd0);
    rst_n = 1'b1;
    tick(1'b0);

    // Combinational table from the empty-scoreboard state.
    for (int i = 0; i < 11; i++) begin
      id_valid = vecs[i].valid; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_u1 = vecs[i].u1; id_u2 = vecs[i].u2; id_rd = vecs[i].rd; id_rw = vecs[i].rw;
      id_mdu = vecs[i].mdu; ex_mr = vecs[i].exmr; ex_rd = vecs[i].exrd;
      flush = vecs[i].flush; wb_rw = vecs[i].wbrw; mdu_done = vecs[i].done;
      mdu_rd = vecs[i].mdurd;
      #2;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_bubble", i), 32'(bubble), 32'(vecs[i].e_bubble));
      chk($sformatf("vec%0d_issue", i), 32'(mdu_issue), 32'(vecs[i].e_issue));
      chk($sformatf("vec%0d_ack", i), 32'(mdu_ack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_sel", i), 32'(wb_sel_mdu), 32'(vecs[i].e_ack));
      tick(vecs[i].e_stall);
    end
    idle();
    #2;
    chk("table_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    chk("table_busy", busy, 32'd0);

    // MDU RAW with a starved result for three cycles, then accepted.
    drive_mdu(5'd7);
    id_rs1 = 5'd1; id_u1 = 1'b1;
    #2;
    chk("raw_issue", 32'(mdu_issue), 32'd1);
    chk("raw_issue_stall", 32'(stall), 32'd0);
    tick(1'b0);
    idle();
    id_valid = 1'b1; id_rs2 = 5'd7; id_u2 = 1'b1; id_rd = 5'd8; id_rw = 1'b1;
    mdu_done = 1'b1; mdu_rd = 5'd7; wb_rw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("arb%0d_busy", k), busy, 32'h0000_0080);
      chk($sformatf("arb%0d_stall", k), 32'(stall), 32'd1);
      chk($sformatf("arb%0d_ack", k), 32'(mdu_ack), 32'd0);
      chk($sformatf("arb%0d_sel", k), 32'(wb_sel_mdu), 32'd0);
      tick(1'b1);
    end
    wb_rw = 1'b0;
    #2;
    chk("arb3_ack", 32'(mdu_ack), 32'd1);
    chk("arb3_sel", 32'(wb_sel_mdu), 32'd1);
    chk("arb3_stall", 32'(stall), 32'd1);
    tick(1'b1);
    mdu_done = 1'b0;
    #2;
    chk("raw_clear_busy", busy, 32'd0);
    chk("raw_clear_stall", 32'(stall), 32'd0);
    tick(1'b0);

    // Structural stall at two in flight, released by one ack.
    drive_mdu(5'd3);
    #2;
    chk("st_issue_a", 32'(mdu_issue), 32'd1);
    tick(1'b0);
    drive_mdu(5'd4);
    #2;
    chk("st_issue_b", 32'(mdu_issue), 32'd1);
    tick(1'b0);
    drive_mdu(5'd5);
    #2;
    chk("st_busy", busy, 32'h0000_0018);
    chk("st_stall", 32'(stall), 32'd1);
    chk("st_no_issue", 32'(mdu_issue), 32'd0);
    tick(1'b1);
    mdu_done = 1'b1; mdu_rd = 5'd3;
    #2;
    chk("st_ack", 32'(mdu_ack), 32'd1);
    chk("st_ack_stall", 32'(stall), 32'd1);
    tick(1'b1);
    mdu_done = 1'b0;
    #2;
    chk("st_release_stall", 32'(stall), 32'd0);
    chk("st_release_issue", 32'(mdu_issue), 32'd1);
    chk("st_release_busy", busy, 32'h0000_0010);
    tick(1'b0);
    idle();
    mdu_done = 1'b1; mdu_rd = 5'd4;
    tick(1'b0);
    mdu_rd = 5'd5;
    #2;
    chk("st_busy_5", busy, 32'h0000_0020);
    tick(1'b0);
    idle();
    #2;
    chk("st_drained", busy, 32'd0);

    // Flush beats a RAW hazard and blocks the MDU issue; then a WAW stall.
    drive_mdu(5'd9);
    tick(1'b0);
    drive_mdu(5'd10);
    id_rs1 = 5'd9; id_u1 = 1'b1; flush = 1'b1;
    #2;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_bubble", 32'(bubble), 32'd1);
    chk("flush_issue", 32'(mdu_issue), 32'd0);
    tick(1'b0);
    idle();
    id_valid = 1'b1; id_rd = 5'd9; id_rw = 1'b1;
    #2;
    chk("flush_busy", busy, 32'h0000_0200);
    chk("waw_stall", 32'(stall), 32'd1);
    tick(1'b1);

    // x0 destination never marks the scoreboard.
    drive_mdu(5'd0);
    #2;
    chk("x0_issue", 32'(mdu_issue), 32'd1);
    tick(1'b0);
    idle();
    mdu_done = 1'b1; mdu_rd = 5'd0;
    #2;
    chk("x0_busy", busy, 32'h0000_0200);
    tick(1'b0);

    while (exp_cnt < 12) begin
      drive_lu();
      tick(1'b1);
    end
    idle();
    #2;
    chk("pre_reset_cnt", 32'(stall_cnt), 32'd12);
    chk("pre_reset_busy9", 32'(busy[9]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", busy, 32'd0);
    chk("async_reset_cnt", 32'(stall_cnt), 32'd0);
    exp_cnt = 0;
    #1;
    rst_n = 1'b1;
    tick(1'b0);

    idle();
    id_valid = 1'b1; id_rs1 = 5'd9; id_u1 = 1'b1;
    #2;
    chk("post_reset_no_raw", 32'(stall), 32'd0);
    tick(1'b0);
    for (int k = 0; k < 17; k++) begin
      drive_lu();
      tick(1'b1);
    end
    idle();
    #2;
    chk("sat_cnt", 32'(stall_cnt), 32'(exp_cnt));
    chk("sat_all_ones", 32'(stall_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
